// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART blocks
package uart_pkg;

    // Default clock cycles per bit: about 115200 baud from a 12 MHz clock
    localparam int unsigned DEFAULT_DIVISOR = 104;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fixed integer divider producing one tick per bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == LAST);

    // A clear always wins so a new frame starts its first bit period on a fresh count
    assign tick_o = wrap && !clear_i;

    // Next count: restart on clear or wrap, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter popping bytes from a have_next/next FIFO
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR   = DEFAULT_DIVISOR,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  byte_t data_i,
    input  logic  have_next_i,
    output logic  next_o,
    output logic  tx_o,
    output logic  busy_o
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t  state_q,   state_d;
    byte_t      shift_q,   shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       tx_q,      tx_d;
    logic       next_q,    next_d;
    logic       busy_q,    busy_d;

    logic       baud_clear;
    logic       bit_done;

    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (baud_clear),
        .tick_o  (bit_done)
    );

    // Frame sequencing; every output is computed one cycle ahead so it leaves a flop
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        next_d     = 1'b0;
        baud_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // Capture the FIFO head on the same edge that requests the pop
                if (have_next_i) begin
                    shift_d    = data_i;
                    bit_idx_d  = 3'd0;
                    state_d    = START;
                    next_d     = 1'b1;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_clear = 1'b1;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end

            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end

            STOP: begin
                tx_d = 1'b1;
                // bit_idx is reused to count stop bit periods
                if (bit_done) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_idx_d = 3'd0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line idle immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            next_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            next_q    <= next_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign next_o = next_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DIV = 4;

    logic  clk = 1'b0;
    logic  rst;
    byte_t data1, data2;
    logic  have1, have2;
    logic  next1, tx1, busy1;
    logic  next2, tx2, busy2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.DIVISOR(DIV), .STOP_BITS(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .data_i(data1), .have_next_i(have1),
        .next_o(next1), .tx_o(tx1), .busy_o(busy1)
    );

    uart_tx #(.DIVISOR(DIV), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .reset_i(rst), .data_i(data2), .have_next_i(have2),
        .next_o(next2), .tx_o(tx2), .busy_o(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 2) ? tx2 : tx1;
    endfunction

    function automatic logic next_of(input int sel);
        return (sel == 2) ? next2 : next1;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 2) ? busy2 : busy1;
    endfunction

    task automatic set_fifo(input int sel, input logic h, input byte_t d);
        if (sel == 2) begin
            have2 = h;
            data2 = d;
        end else begin
            have1 = h;
            data1 = d;
        end
    endtask

    // Waits for a start bit, then records one whole frame against the expected byte.
    // A pop empties the modelled FIFO and leaves 0xFF on its head.
    task automatic capture_frame(input int sel, input int nstop, input byte_t exp,
                                 output logic found, output byte_t rx, output int bad,
                                 output int pulses, output int busy_cnt, output logic next_at0);
        int   len;
        int   slot;
        logic lvl;
        logic exp_lvl;
        found = 1'b0; rx = 8'h00; bad = 0; pulses = 0; busy_cnt = 0; next_at0 = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (tx_of(sel) == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        len = (9 + nstop) * DIV;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            lvl  = tx_of(sel);
            slot = c / DIV;
            if (slot == 0)      exp_lvl = 1'b0;
            else if (slot <= 8) exp_lvl = exp[slot-1];
            else                exp_lvl = 1'b1;
            if (lvl !== exp_lvl) bad++;
            if (slot >= 1 && slot <= 8 && (c % DIV) == DIV / 2) rx[slot-1] = lvl;
            if (next_of(sel)) begin
                pulses++;
                if (c == 0) next_at0 = 1'b1;
                set_fifo(sel, 1'b0, 8'hFF);
            end
            if (busy_of(sel)) busy_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic  found, n0;
        byte_t rx;
        int    bad, pulses, bcnt, viol;
        byte_t fifo_q[$];
        int    pulse_cyc[$];
        byte_t got_bytes[$];
        logic  log_tx[200];
        byte_t b2b_exp[4];
        int    i;

        b2b_exp[0] = 8'hDE; b2b_exp[1] = 8'hAD; b2b_exp[2] = 8'hBE; b2b_exp[3] = 8'hEF;

        // Reset and idle hold
        rst = 1'b1; have1 = 1'b0; have2 = 1'b0; data1 = 8'h00; data2 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_next", next1, 0);
        check("rst_busy", busy1, 0);
        @(posedge clk); #1 rst = 1'b0;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || next1 !== 1'b0 || busy1 !== 1'b0) viol++;
            if (tx2 !== 1'b1 || next2 !== 1'b0 || busy2 !== 1'b0) viol++;
        end
        check("idle_hold", viol, 0);

        // Single byte 0xDE
        @(posedge clk); #1 set_fifo(1, 1'b1, 8'hDE);
        capture_frame(1, 1, 8'hDE, found, rx, bad, pulses, bcnt, n0);
        check("single_found", found, 1);
        check("single_byte", rx, 8'hDE);
        check("single_shape", bad, 0);
        check("single_pulses", pulses, 1);
        check("single_next_at0", n0, 1);
        check("single_busy_len", bcnt, 40);
        @(negedge clk);
        check("single_post_tx", tx1, 1);
        check("single_post_busy", busy1, 0);

        // Back-to-back frames from a preloaded FIFO
        fifo_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        @(posedge clk); #1 set_fifo(1, 1'b1, fifo_q[0]);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            log_tx[c] = tx1;
            if (next1) begin
                pulse_cyc.push_back(c);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (fifo_q.size() != 0) set_fifo(1, 1'b1, fifo_q[0]);
            else                    set_fifo(1, 1'b0, 8'hFF);
        end
        i = 0;
        while (i + 40 <= 200) begin
            if (log_tx[i] == 1'b0) begin
                rx = 8'h00;
                for (int k = 0; k < 8; k++) rx[k] = log_tx[i + 4 * (k + 1) + 2];
                got_bytes.push_back(rx);
                i += 40;
            end else begin
                i++;
            end
        end
        check("b2b_frames", got_bytes.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("b2b_byte%0d", k), (k < got_bytes.size()) ? 32'(got_bytes[k]) : 32'hFFFF_FFFF, b2b_exp[k]);
        check("b2b_pulses", pulse_cyc.size(), 4);
        for (int k = 1; k < 4; k++)
            check($sformatf("b2b_gap%0d", k), (k < pulse_cyc.size()) ? pulse_cyc[k] - pulse_cyc[k-1] : -1, 41);
        viol = 0;
        for (int c = 170; c < 200; c++) if (log_tx[c] !== 1'b1) viol++;
        check("b2b_idle_tail", viol, 0);

        // Two stop bits on the second instance
        @(posedge clk); #1 set_fifo(2, 1'b1, 8'h55);
        capture_frame(2, 2, 8'h55, found, rx, bad, pulses, bcnt, n0);
        check("stop2_found", found, 1);
        check("stop2_byte", rx, 8'h55);
        check("stop2_shape", bad, 0);
        check("stop2_busy_len", bcnt, 44);
        @(negedge clk);
        check("stop2_post_busy", busy2, 0);

        // Reset in the third data bit of 0x12
        @(posedge clk); #1 set_fifo(1, 1'b1, 8'h12);
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (next1) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_pop_seen", found, 1);
        set_fifo(1, 1'b0, 8'hFF);
        repeat (13) @(negedge clk);
        check("mr_pre_tx", tx1, 0);
        rst = 1'b1;
        #1;
        check("mr_tx_async", tx1, 1);
        check("mr_busy_async", busy1, 0);
        check("mr_next_async", next1, 0);
        @(posedge clk); @(posedge clk);
        #1 set_fifo(1, 1'b1, 8'h34); rst = 1'b0;
        capture_frame(1, 1, 8'h34, found, rx, bad, pulses, bcnt, n0);
        check("mr_found", found, 1);
        check("mr_byte", rx, 8'h34);
        check("mr_shape", bad, 0);
        check("mr_pulses", pulses, 1);
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (next1 !== 1'b0 || tx1 !== 1'b1) viol++;
        end
        check("mr_after_quiet", viol, 0);

        // Head changes to 0xFF right after the pop of 0x00
        @(posedge clk); #1 set_fifo(1, 1'b1, 8'h00);
        capture_frame(1, 1, 8'h00, found, rx, bad, pulses, bcnt, n0);
        check("stab_found", found, 1);
        check("stab_byte", rx, 8'h00);
        check("stab_shape", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter directly downstream of fifo_spram.
- Pops bytes from the FIFO with a have_next/next handshake and shifts each one out on tx_o as a standard 8N1 (or 8N2) UART frame, LSB first.
- Baud timing comes from a fixed integer clock divider.
- Sits between the CSR-fed TX FIFO and the top-level UART TX pin.

Parameters:
- DIVISOR, 104, clock cycles per bit period; legal range 2..65535 (104 gives about 115200 baud at 12 MHz).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk_i  input  1  system clock, rising-edge.
- reset_i  input  1  asynchronous, active-high reset.
- data_i  input  8  byte at the FIFO head (fifo_spram data); valid whenever have_next_i=1.
- have_next_i  input  1  FIFO non-empty (fifo_spram have_next).
- next_o  output  1  one-cycle pop strobe to the FIFO (fifo_spram next).
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values (asynchronous): state=IDLE, tx_o=1, next_o=0, busy_o=0, baud counter=0, bit index=0, shift register=0.
- States:
  - IDLE: tx_o=1. Sample have_next_i on each edge. If 1, capture data_i into the shift register, go to START, register next_o=1 for exactly the following cycle, and drive tx_o=0.
  - START: tx_o=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for DIVISOR cycles per bit. Shift right and increment the index at each bit boundary. After bit 7, go to STOP.
  - STOP: tx_o=1 for STOP_BITS*DIVISOR cycles, then go to IDLE.
- Frame length: (9+STOP_BITS)*DIVISOR cycles from the first tx_o=0 cycle to the last stop cycle.
- IDLE occupies at least one cycle between frames, so back-to-back frames carry exactly one extra high cycle.
- All outputs are registered; there is no combinational path from any input to any output.
- Baud counter:
  - Width $clog2(DIVISOR).
  - Loads 0 on entry to START. Counts to DIVISOR-1, then wraps to 0 and asserts an internal bit_done for that cycle.
- Handshake:
  - data_i is captured on the same edge that sets next_o, before the FIFO pops.
  - have_next_i is ignored outside IDLE, so FIFO pop latency up to one frame time is tolerated.
  - Exactly one next_o pulse per transmitted byte. next_o is never asserted when have_next_i was 0 at the capture edge.
- FIFO empty: stay in IDLE with tx_o=1 indefinitely. busy_o=0.
- have_next_i rises during a frame: no effect until the frame returns to IDLE.
- Reset mid-frame: tx_o goes to 1 immediately (asynchronous). The partially sent byte is dropped and is not re-popped. After release, the block restarts from IDLE.
- data_i changes mid-frame: no effect, because the frame uses the shift-register copy.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP).
  - byte_t typedef (logic [7:0]).
  - Default DIVISOR constant.
- One sub-module, uart_baud_gen: parameter DIVISOR; inputs clk_i, reset_i, clear_i; output tick_o.
  - clear_i is asserted on the IDLE->START transition.
  - tick_o pulses every DIVISOR cycles.
  - It is reused later by the RX side.

Test Plan (DIVISOR=4, STOP_BITS=1 unless noted):
- Reset idle: assert reset_i for 2 cycles with have_next_i=0 -> tx_o=1, next_o=0, busy_o=0 held for 50 cycles.
- Single byte: data_i=0xDE, have_next_i=1 for one cycle -> one next_o pulse in the cycle after the capture edge; tx_o sequence per 4-cycle slot = 0 | 0,1,1,1,1,0,1,1 | 1; busy_o high for 40 cycles.
- Back-to-back frames: FIFO model preloaded with 0xDE,0xAD,0xBE,0xEF -> four next_o pulses 41 cycles apart; decoded bytes 0xDE,0xAD,0xBE,0xEF in order; have_next_i low afterwards leaves tx_o=1.
- Two stop bits: STOP_BITS=2, data_i=0x55 -> stop level high for 8 cycles; frame length 44 cycles; bits 1,0,1,0,1,0,1,0.
- Mid-frame reset: assert reset_i in the 3rd data bit of 0x12 -> tx_o=1 in the same cycle; after release with 0x34 pending, a clean 0x34 frame and exactly one additional next_o pulse.
- Data stability: change data_i to 0xFF mid-frame while transmitting 0x00 -> all eight data slots remain 0.
